// File: rtl/dmem_store.sv
// Purpose : CPU store path. Queues aligned RAM stores in a small in-order FIFO and writes the LED and OUT registers directly.
// Latency : a RAM store accepted at edge N shows on ram_we in the following cycle. LED, OUT and err update at edge N.
// Backpr. : stall is high while a RAM store meets a full buffer. A pop in the same cycle does not clear it. The RAM drains via ram_ready.
//
// Ports
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   we, a, wd       : CPU store request, byte address, data (held by CPU while stall=1)
//   stall           : request not taken this cycle
//   ram_we/a/wd     : head-of-buffer write; retires on ram_we & ram_ready
//   ram_ready       : RAM accepts the head write this cycle
//   leds, outreg    : memory-mapped output registers (byte 260 and byte 264)
//   empty           : store buffer empty (fence/idle)
//   err             : sticky flag for stores to read-only, unmapped or misaligned addresses

module dmem_store #(
    parameter int DEPTH     = 4,
    parameter int RAM_WORDS = 64,
    localparam int AW       = $clog2(RAM_WORDS),
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [31:0]   a,
    input  logic [31:0]   wd,
    output logic          stall,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [31:0]   ram_wd,
    input  logic          ram_ready,
    output logic [7:0]    leds,
    output logic [31:0]   outreg,
    output logic          empty,
    output logic          err
);

    localparam logic [31:0] LED_ADDR = 32'd260;
    localparam logic [31:0] OUT_ADDR = 32'd264;
    localparam logic [31:0] RAM_TOP  = 32'(4 * RAM_WORDS);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   dat;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    leds_q;
    logic [31:0]   outreg_q;
    logic          err_q;

    logic is_ram, is_led, is_out, is_bad;
    logic full, push, pop;

    // Address decode. The switch address (256) has no store target, so it
    // falls into is_bad together with unmapped and misaligned addresses.
    always_comb begin
        is_ram = we && (a < RAM_TOP) && (a[1:0] == 2'b00);
        is_led = we && (a == LED_ADDR);
        is_out = we && (a == OUT_ADDR);
        is_bad = we && !is_ram && !is_led && !is_out;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Stall uses the registered full flag only. A pop in the same cycle
    // frees a slot, but the store is taken on the following cycle.
    assign stall = is_ram && full;
    assign push  = is_ram && !full;
    assign pop   = !empty && ram_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            leds_q   <= '0;
            outreg_q <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (is_led) leds_q   <= wd[7:0];
            if (is_out) outreg_q <= wd;
            if (is_bad) err_q    <= 1'b1;
        end
    end

    // Entry storage has no reset. Stale contents cannot leak out because
    // the head outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{addr: a[AW+1:2], dat: wd};
    end

    assign ram_we = !empty;
    assign ram_a  = empty ? '0 : mem_q[rd_ptr_q].addr;
    assign ram_wd = empty ? '0 : mem_q[rd_ptr_q].dat;

    assign leds   = leds_q;
    assign outreg = outreg_q;
    assign err    = err_q;

endmodule
